// File: rtl/sap_pkg.sv
// sap_pkg: shared state encodings, ASCII constants and hex helper for the
// SAP-1 memory dump path (mem_dump_tx and its UART byte transmitter).
package sap_pkg;

   // Dump sequencer states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ      = 2'd1,
      EMIT      = 2'd2,
      WAIT_LAST = 2'd3
   } dump_state_t;

   // Line framing characters.
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] COLON = 8'h3A;

   // Uppercase ASCII hex digit for one nibble: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/mem_dump_tx_if.sv
// mem_dump_tx_if: SAP-1 memory read port borrowed by the dump block while the
// CPU is stopped. The master drives address/enable and the mux select, the
// memory side returns read data.
interface mem_dump_tx_if #(
   parameter int AW = 4
);
   logic [AW-1:0] ABUS;    // read address, meaningful only while bus_en=1
   logic          nCE;     // memory chip enable, active low
   logic          bus_en;  // top-level mux select: dump block owns ABUS/nCE
   logic [7:0]    DBUS;    // memory read data

   modport master (
      output ABUS,
      output nCE,
      output bus_en,
      input  DBUS
   );

   modport slave (
      input  ABUS,
      input  nCE,
      input  bus_en,
      output DBUS
   );
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser. A 10-bit shift register (start, 8 data LSB
// first, stop) is clocked out one bit per CLKS_PER_BIT cycles. byte_ready is
// also raised in the final cycle of the stop bit so a waiting byte starts
// immediately, giving back-to-back frames with no idle gap.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       CLR,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       tx
);

   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] baud_cnt_reg;
   logic [3:0]    bit_cnt_reg;
   logic [9:0]    shift_reg;
   logic          active_reg;
   logic          frame_end;

   // Last clock of the stop bit: the frame is complete after this edge.
   assign frame_end  = active_reg && (bit_cnt_reg == 4'd9) && (baud_cnt_reg == BAUD_LAST);
   assign byte_ready = !active_reg || frame_end;

   // Line is the LSB of the shift register; idle fill is all ones.
   assign tx = shift_reg[0];

   // Frame load, baud timing and bit shifting.
   always_ff @(posedge clk) begin
      if (CLR) begin
         shift_reg    <= '1;
         active_reg   <= 1'b0;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
      end else if (byte_valid && byte_ready) begin
         shift_reg    <= {1'b1, byte_data, 1'b0};
         active_reg   <= 1'b1;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
      end else if (active_reg) begin
         if (baud_cnt_reg == BAUD_LAST) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {1'b1, shift_reg[9:1]};
            if (bit_cnt_reg == 4'd9) begin
               active_reg <= 1'b0;
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
         end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: reads every SAP-1 RAM word while the CPU is stopped and sends
// each one as an ASCII hex line over an 8N1 UART.
// Build option MEM_DUMP_ADDR_EN: when defined every line carries an address
// digit and ':' prefix ("3:A7\r\n"); otherwise lines are "A7\r\n".
module mem_dump_tx
   import sap_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200,
   parameter int AW     = 4,     // must match the AW of the connected interface
   parameter int SETTLE = 2
) (
   input  logic          clk,
   input  logic          CLR,
   input  logic          start,
   input  logic          run,
   mem_dump_tx_if.master mem,
   output logic          tx,
   output logic          busy,
   output logic          done
);

   localparam int            CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam logic [AW-1:0] LAST_ADDR    = '1;
   localparam int            SW           = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);
`ifdef MEM_DUMP_ADDR_EN
   localparam logic [2:0]    LINE_LAST    = 3'd5;
`else
   localparam logic [2:0]    LINE_LAST    = 3'd3;
`endif

   dump_state_t   state_reg, state_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [SW-1:0] settle_reg, settle_next;
   logic [2:0]    idx_reg, idx_next;
   logic [7:0]    data_reg, data_next;
   logic          done_reg, done_next;
   logic          start_q_reg;
   logic          start_rise;
   logic          byte_valid;
   logic          byte_ready;
   logic [7:0]    line_byte;

   assign start_rise = start && !start_q_reg;

   // Memory bus is only claimed during the settle window of a read.
   assign mem.bus_en = (state_reg == READ);
   assign mem.nCE    = (state_reg != READ);
   assign mem.ABUS   = (state_reg == READ) ? addr_reg : '0;
   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;

`ifdef MEM_DUMP_ADDR_EN
   // Address prefix digit: low nibble of the address (one digit covers AW<=4).
   logic [3:0] addr_nib;
   assign addr_nib = 4'(addr_reg);

   // Byte of the current line: addr, ':', hi, lo, CR, LF.
   always_comb begin
      line_byte = LF;
      case (idx_reg)
         3'd0:    line_byte = hex_ascii(addr_nib);
         3'd1:    line_byte = COLON;
         3'd2:    line_byte = hex_ascii(data_reg[7:4]);
         3'd3:    line_byte = hex_ascii(data_reg[3:0]);
         3'd4:    line_byte = CR;
         default: line_byte = LF;
      endcase
   end
`else
   // Byte of the current line: hi, lo, CR, LF.
   always_comb begin
      line_byte = LF;
      case (idx_reg)
         3'd0:    line_byte = hex_ascii(data_reg[7:4]);
         3'd1:    line_byte = hex_ascii(data_reg[3:0]);
         3'd2:    line_byte = CR;
         default: line_byte = LF;
      endcase
   end
`endif

   // Next-state logic: start gating, settle timing, line sequencing, done.
   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      settle_next = settle_reg;
      idx_next    = idx_reg;
      data_next   = data_reg;
      done_next   = 1'b0;
      byte_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_rise && !run) begin
               state_next  = READ;
               addr_next   = '0;
               settle_next = '0;
            end
         end
         READ: begin
            if (settle_reg == SETTLE_LAST) begin
               data_next  = mem.DBUS;
               idx_next   = '0;
               state_next = EMIT;
            end else begin
               settle_next = settle_reg + 1'b1;
            end
         end
         EMIT: begin
            byte_valid = 1'b1;
            if (byte_ready) begin
               if (idx_reg == LINE_LAST) begin
                  idx_next = '0;
                  if (addr_reg == LAST_ADDR) begin
                     state_next = WAIT_LAST;
                  end else begin
                     addr_next   = addr_reg + 1'b1;
                     settle_next = '0;
                     state_next  = READ;
                  end
               end else begin
                  idx_next = idx_reg + 3'd1;
               end
            end
         end
         WAIT_LAST: begin
            // byte_ready rises in the final stop-bit clock, so done lands
            // on the first clock after the last frame.
            if (byte_ready) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and datapath registers; start history is kept through reset so a
   // level held across CLR is not mistaken for a new request.
   always_ff @(posedge clk) begin
      if (CLR) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         settle_reg  <= '0;
         idx_reg     <= '0;
         data_reg    <= '0;
         done_reg    <= 1'b0;
         start_q_reg <= start;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         settle_reg  <= settle_next;
         idx_reg     <= idx_next;
         data_reg    <= data_next;
         done_reg    <= done_next;
         start_q_reg <= start;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk       (clk),
      .CLR       (CLR),
      .byte_valid(byte_valid),
      .byte_data (line_byte),
      .byte_ready(byte_ready),
      .tx        (tx)
   );

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx: drives a fast-baud instance with table-driven and random RAM
// contents, decodes its UART line and compares against a text-level model of
// the dump; a second instance at default parameters checks real bit timing.
`timescale 1ns/1ps
module tb_mem_dump_tx;

   localparam int AW        = 4;
   localparam int NW        = 1 << AW;
   localparam int CPB       = 5;
   localparam int TB_BAUD   = 115200;
   localparam int TB_CLK_HZ = CPB * TB_BAUD;
   localparam int SET       = 2;
   localparam int DEF_CPB   = 434;
`ifdef MEM_DUMP_ADDR_EN
   localparam int LL = 6;
`else
   localparam int LL = 4;
`endif
   localparam int DUMP_LIMIT = NW * LL * 10 * CPB + NW * 8 + 200;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   // Fast instance
   logic clr, start, run, tx, busy, done;
   logic [7:0] ram [NW];
   mem_dump_tx_if #(.AW(AW)) mif ();
   assign mif.DBUS = ram[mif.ABUS];

   mem_dump_tx #(.CLK_HZ(TB_CLK_HZ), .BAUD(TB_BAUD), .AW(AW), .SETTLE(SET)) dut (
      .clk(clk), .CLR(clr), .start(start), .run(run), .mem(mif),
      .tx(tx), .busy(busy), .done(done));

   // Default-parameter instance
   logic clr2, start2, run2, tx2, busy2, done2;
   mem_dump_tx_if #(.AW(AW)) mif2 ();
   assign mif2.DBUS = 8'hA5;

   mem_dump_tx dut2 (
      .clk(clk), .CLR(clr2), .start(start2), .run(run2), .mem(mif2),
      .tx(tx2), .busy(busy2), .done(done2));

   int tests = 0;
   int fails = 0;
   logic [7:0] rx_q [$];
   logic [7:0] exp_q [$];
   int rd_q [$];
   int done_total = 0;
   int done2_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // UART receiver: mid-bit sampling of the fast instance's line.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("uart stop bit", tx, 1'b1);
            rx_q.push_back(b);
         end
      end
   end

   // Memory bus watcher: width of each nCE low window, address stability.
   initial begin
      int len;
      logic [AW-1:0] a0;
      bit moved;
      len = 0; a0 = '0; moved = 0;
      forever begin
         @(negedge clk);
         if (mif.nCE === 1'b0) begin
            if (len == 0) begin
               a0 = mif.ABUS;
               moved = 0;
            end else if (mif.ABUS !== a0) begin
               moved = 1;
            end
            if (mif.bus_en !== 1'b1) moved = 1;
            len++;
         end else if (len != 0) begin
            check("nCE low width", len, SET);
            check("ABUS stable during read", moved, 0);
            rd_q.push_back(int'(a0));
            len = 0;
         end
      end
   end

   // Count clocks with done high on both instances.
   initial begin
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_total++;
         if (done2 === 1'b1) done2_total++;
      end
   end

   // Reference text of a full dump from the current RAM image.
   task automatic model_dump();
      string hx;
      hx = "0123456789ABCDEF";
      exp_q.delete();
      for (int a = 0; a < NW; a++) begin
`ifdef MEM_DUMP_ADDR_EN
         exp_q.push_back(8'(hx.getc(a % 16)));
         exp_q.push_back(8'h3A);
`endif
         exp_q.push_back(8'(hx.getc(int'(ram[a]) / 16)));
         exp_q.push_back(8'(hx.getc(int'(ram[a]) % 16)));
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   task automatic fill_ram(input int pat);
      for (int i = 0; i < NW; i++) begin
         case (pat)
            0:       ram[i] = 8'(i * 17);
            1:       ram[i] = 8'($urandom_range(0, 255));
            2:       ram[i] = (i == 5) ? 8'h3C : 8'($urandom);
            default: ram[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
         endcase
      end
   endtask

   // One start request and all of its observable consequences.
   task automatic apply(input string name, input logic run_lvl, input bit run_mid, input bit hold,
                        input logic exp_busy, input int exp_bytes, input int exp_done);
      int t, d0;
      bit bad;
      model_dump();
      rx_q.delete();
      rd_q.delete();
      d0 = done_total;
      bad = 0;
      run = run_lvl;
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      check({name, ": busy after start"}, busy, exp_busy);
      if (exp_done != 0) begin
         t = 0;
         while (done !== 1'b1 && t < DUMP_LIMIT) begin
            @(negedge clk);
            t++;
            if (run_mid && t == DUMP_LIMIT / 3) run = 1'b1;
         end
         check({name, ": done within budget"}, done, 1'b1);
         check({name, ": busy low with done"}, busy, 1'b0);
         check({name, ": tx idle with done"}, tx, 1'b1);
      end
      for (int i = 0; i < 30 * CPB; i++) begin
         @(negedge clk);
         if (exp_busy == 1'b0 &&
             (busy !== 1'b0 || mif.bus_en !== 1'b0 || mif.nCE !== 1'b1 || tx !== 1'b1))
            bad = 1;
      end
      check({name, ": stayed idle"}, bad, 0);
      run = 1'b0;
      check({name, ": done pulse count"}, done_total - d0, exp_done);
      check({name, ": byte count"}, rx_q.size(), exp_bytes);
      for (int i = 0; i < exp_bytes && i < rx_q.size(); i++)
         check($sformatf("%s: byte %0d", name, i), rx_q[i], exp_q[i]);
      check({name, ": read count"}, rd_q.size(), (exp_bytes != 0) ? NW : 0);
      for (int i = 0; i < rd_q.size(); i++)
         check($sformatf("%s: read addr %0d", name, i), rd_q[i], i);
      check({name, ": bus released"}, {mif.bus_en, mif.nCE}, 2'b01);
      $display("[TB] %s: %0d bytes, %0d reads, %0d done", name, rx_q.size(), rd_q.size(),
               done_total - d0);
   endtask

   typedef struct {
      string name;
      logic  run_lvl;
      int    pat;
      bit    run_mid;
      logic  exp_busy;
      int    exp_bytes;
      int    exp_done;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int t, d0, nl, lw, tz;
      bit bad2;
      logic [7:0] fb;

      vecs[0] = '{"ramp",        1'b0, 0, 1'b0, 1'b1, NW * LL, 1};
      vecs[1] = '{"run_high",    1'b1, 1, 1'b0, 1'b0, 0,       0};
      vecs[2] = '{"random_run",  1'b0, 1, 1'b1, 1'b1, NW * LL, 1};
      vecs[3] = '{"addr5_3C",    1'b0, 2, 1'b0, 1'b1, NW * LL, 1};
      vecs[4] = '{"alt_00_FF",   1'b0, 3, 1'b0, 1'b1, NW * LL, 1};

      clr = 1'b1; start = 1'b0; run = 1'b0;
      clr2 = 1'b1; start2 = 1'b0; run2 = 1'b0;
      fill_ram(0);
      repeat (4) @(negedge clk);
      clr = 1'b0; clr2 = 1'b0;
      @(negedge clk);
      check("reset tx", tx, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset nCE", mif.nCE, 1'b1);
      check("reset bus_en", mif.bus_en, 1'b0);
      check("reset ABUS", mif.ABUS, 0);

      // Table of dump scenarios.
      for (int v = 0; v < 5; v++) begin
         fill_ram(vecs[v].pat);
         apply(vecs[v].name, vecs[v].run_lvl, vecs[v].run_mid, 1'b0,
               vecs[v].exp_busy, vecs[v].exp_bytes, vecs[v].exp_done);
      end

      // CLR during a frame once address 7 has been read.
      fill_ram(1);
      rx_q.delete();
      rd_q.delete();
      d0 = done_total;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (rd_q.size() < 8 && t < DUMP_LIMIT) begin
         @(negedge clk);
         t++;
      end
      check("clr: reached addr 7", rd_q.size() >= 8, 1);
      t = 0;
      while (tx !== 1'b0 && t < 20 * CPB) begin
         @(negedge clk);
         t++;
      end
      check("clr: mid-frame before abort", tx, 1'b0);
      clr = 1'b1;
      @(negedge clk);
      check("clr: tx next clk", tx, 1'b1);
      check("clr: busy next clk", busy, 1'b0);
      check("clr: bus_en next clk", mif.bus_en, 1'b0);
      clr = 1'b0;
      repeat (15 * CPB) @(negedge clk);
      check("clr: no done pulse", done_total - d0, 0);
      check("clr: still idle", busy, 1'b0);
      $display("[TB] clr_abort: %0d reads before abort", rd_q.size());
      apply("after_clr", 1'b0, 1'b0, 1'b0, 1'b1, NW * LL, 1);

      // start held high: one dump, then a fresh edge gives a second one.
      fill_ram(1);
      apply("held_start", 1'b0, 1'b0, 1'b1, 1'b1, NW * LL, 1);
      start = 1'b0;
      @(negedge clk);
      fill_ram(0);
      apply("second_edge", 1'b0, 1'b0, 1'b0, 1'b1, NW * LL, 1);

      // Default parameters: settle window and first start-bit length.
      bad2 = 0;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      nl = 0;
      t = 0;
      while (tx2 !== 1'b0 && t < 100) begin
         if (mif2.nCE === 1'b0) begin
            nl++;
            if (mif2.ABUS !== 0 || mif2.bus_en !== 1'b1) bad2 = 1;
         end
         @(negedge clk);
         t++;
      end
      check("default: nCE low width", nl, SET);
      check("default: ABUS/bus_en during read", bad2, 0);
      // First line byte for DBUS=A5: '0' with the address prefix, else 'A'.
`ifdef MEM_DUMP_ADDR_EN
      fb = 8'h30;
`else
      fb = 8'h41;
`endif
      tz = 0;
      while (tz < 8 && fb[tz] == 1'b0) tz++;
      lw = 0;
      while (tx2 === 1'b0 && lw < 5000) begin
         lw++;
         @(negedge clk);
      end
      check("default: first low run", lw, DEF_CPB * (1 + tz));
      clr2 = 1'b1;
      @(negedge clk);
      check("default clr: tx", tx2, 1'b1);
      check("default clr: busy", busy2, 1'b0);
      clr2 = 1'b0;
      repeat (10) @(negedge clk);
      check("default: no done", done2_total, 0);
      $display("[TB] default_timing: nCE %0d clks, first low run %0d clks", nl, lw);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
